// File: rtl/sat_pkg.sv
// Shared SAT-node types: term/clause layout, literal value encoding and
// clause status, plus small literal helpers used by the classifier.
package sat_pkg;

    localparam int NUM_CLAUSES_DEF  = 16;
    localparam int TERMS_PER_CLAUSE = 3;
    localparam int VAR_ID_WIDTH     = 8;
    localparam int VALUE_WIDTH      = 2;
    localparam int TERM_WIDTH       = VAR_ID_WIDTH + VALUE_WIDTH + 1;
    localparam int CLAUSE_WIDTH     = TERMS_PER_CLAUSE * TERM_WIDTH;

    localparam logic [VALUE_WIDTH-1:0] VAL_FALSE   = 2'b00;
    localparam logic [VALUE_WIDTH-1:0] VAL_TRUE    = 2'b01;
    localparam logic [VALUE_WIDTH-1:0] VAL_UNKNOWN = 2'b10;
    localparam logic [VALUE_WIDTH-1:0] VAL_RSVD    = 2'b11;

    typedef struct packed {
        logic [VAR_ID_WIDTH-1:0] var_id;
        logic [VALUE_WIDTH-1:0]  value;
        logic                    neg;
    } term_t;

    typedef enum logic [1:0] {
        CL_SAT,
        CL_CONFLICT,
        CL_UNIT,
        CL_UNDECIDED
    } clause_status_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_t;

    // Both upper encodings (UNKNOWN and the reserved code) read as unknown.
    function automatic logic lit_unknown(input term_t t);
        return t.value[1];
    endfunction

    function automatic logic lit_true(input term_t t);
        return !t.value[1] && (t.value[0] ^ t.neg);
    endfunction

endpackage

// File: rtl/clause_classify.sv
// Combinational classifier for one 3-term clause: SAT / CONFLICT / UNIT /
// UNDECIDED, plus the variable and satisfying value of the lone unknown
// literal when the clause is UNIT.
module clause_classify
    import sat_pkg::*;
(
    input  logic [CLAUSE_WIDTH-1:0] clause_i,
    output clause_status_t          status_o,
    output logic [VAR_ID_WIDTH-1:0] unit_var_o,
    output logic                    unit_value_o
);

    term_t                       terms [TERMS_PER_CLAUSE];
    logic [TERMS_PER_CLAUSE-1:0] is_true;
    logic [TERMS_PER_CLAUSE-1:0] is_unk;

    // Unpack the clause (term0 in the MSBs) and evaluate each literal.
    always_comb begin
        for (int i = 0; i < TERMS_PER_CLAUSE; i++) begin
            terms[i]   = term_t'(clause_i[CLAUSE_WIDTH-1-i*TERM_WIDTH -: TERM_WIDTH]);
            is_true[i] = lit_true(terms[i]);
            is_unk[i]  = lit_unknown(terms[i]);
        end
    end

    // Priority classification; a literal that is neither true nor unknown is false.
    always_comb begin
        status_o     = CL_UNDECIDED;
        unit_var_o   = '0;
        unit_value_o = 1'b0;
        if (|is_true) begin
            status_o = CL_SAT;
        end else if (is_unk == '0) begin
            status_o = CL_CONFLICT;
        end else if ($countones(is_unk) == 1) begin
            status_o = CL_UNIT;
        end
        // Pick the unknown literal; only meaningful when status is UNIT.
        for (int i = TERMS_PER_CLAUSE - 1; i >= 0; i--) begin
            if (is_unk[i]) begin
                unit_var_o   = terms[i].var_id;
                unit_value_o = ~terms[i].neg;
            end
        end
    end

endmodule

// File: rtl/clause_scanner.sv
// Sweeps the clause memory one address per cycle through its registered read
// port, classifies each returned clause and accumulates the aggregate status,
// the first conflict and the first unit clause for the decision logic.
module clause_scanner
    import sat_pkg::*;
#(
    parameter  int NUM_CLAUSES = NUM_CLAUSES_DEF,
    localparam int AW          = $clog2(NUM_CLAUSES),
    localparam int CW          = $clog2(NUM_CLAUSES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [CW-1:0]           num_clauses_i,
    output logic [AW-1:0]           mem_read_addr_o,
    input  logic [CLAUSE_WIDTH-1:0] mem_read_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    all_sat_o,
    output logic                    conflict_o,
    output logic [AW-1:0]           conflict_addr_o,
    output logic                    unit_found_o,
    output logic [AW-1:0]           unit_addr_o,
    output logic [VAR_ID_WIDTH-1:0] unit_var_o,
    output logic                    unit_value_o,
    output logic [CW-1:0]           sat_count_o
);

    scan_state_t             state_q;
    logic [CW-1:0]           n_q;
    logic [AW-1:0]           addr_q;
    logic                    eval_valid_q;
    logic [AW-1:0]           eval_addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    all_sat_q;
    logic                    conflict_q;
    logic [AW-1:0]           conflict_addr_q;
    logic                    unit_found_q;
    logic [AW-1:0]           unit_addr_q;
    logic [VAR_ID_WIDTH-1:0] unit_var_q;
    logic                    unit_value_q;
    logic [CW-1:0]           sat_count_q;

    clause_status_t          cl_status;
    logic [VAR_ID_WIDTH-1:0] cl_unit_var;
    logic                    cl_unit_value;
    logic [CW-1:0]           n_clamped;
    logic                    last_issue;
    logic                    hit_conflict;

    clause_classify u_classify (
        .clause_i     (mem_read_data_i),
        .status_o     (cl_status),
        .unit_var_o   (cl_unit_var),
        .unit_value_o (cl_unit_value)
    );

    // Oversized requests are clamped so the address can never wrap.
    assign n_clamped    = (num_clauses_i > CW'(NUM_CLAUSES)) ? CW'(NUM_CLAUSES) : num_clauses_i;
    assign last_issue   = (CW'(addr_q) == n_q - CW'(1));
    assign hit_conflict = eval_valid_q && (cl_status == CL_CONFLICT);

    // Scan FSM plus result accumulation; every output is a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            n_q             <= '0;
            addr_q          <= '0;
            eval_valid_q    <= 1'b0;
            eval_addr_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            all_sat_q       <= 1'b0;
            conflict_q      <= 1'b0;
            conflict_addr_q <= '0;
            unit_found_q    <= 1'b0;
            unit_addr_q     <= '0;
            unit_var_q      <= '0;
            unit_value_q    <= 1'b0;
            sat_count_q     <= '0;
        end else begin
            done_q <= 1'b0;

            // eval_valid_q is only ever set in SCAN/DRAIN, so this covers both.
            if (eval_valid_q) begin
                unique case (cl_status)
                    CL_SAT: sat_count_q <= sat_count_q + CW'(1);
                    CL_CONFLICT: begin
                        conflict_q      <= 1'b1;
                        conflict_addr_q <= eval_addr_q;
                        all_sat_q       <= 1'b0;
                    end
                    CL_UNIT: begin
                        all_sat_q <= 1'b0;
                        if (!unit_found_q) begin
                            unit_addr_q  <= eval_addr_q;
                            unit_var_q   <= cl_unit_var;
                            unit_value_q <= cl_unit_value;
                        end
                        unit_found_q <= 1'b1;
                    end
                    default: all_sat_q <= 1'b0;
                endcase
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        n_q             <= n_clamped;
                        addr_q          <= '0;
                        eval_valid_q    <= 1'b0;
                        busy_q          <= 1'b1;
                        all_sat_q       <= 1'b1;
                        conflict_q      <= 1'b0;
                        conflict_addr_q <= '0;
                        unit_found_q    <= 1'b0;
                        unit_addr_q     <= '0;
                        unit_var_q      <= '0;
                        unit_value_q    <= 1'b0;
                        sat_count_q     <= '0;
                        state_q         <= (n_clamped == '0) ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_conflict) begin
                        // Outstanding read is dropped; nothing after a conflict matters.
                        eval_valid_q <= 1'b0;
                        state_q      <= ST_DONE;
                    end else begin
                        eval_valid_q <= 1'b1;
                        eval_addr_q  <= addr_q;
                        if (last_issue) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    eval_valid_q <= 1'b0;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_read_addr_o = addr_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign all_sat_o       = all_sat_q;
    assign conflict_o      = conflict_q;
    assign conflict_addr_o = conflict_addr_q;
    assign unit_found_o    = unit_found_q;
    assign unit_addr_o     = unit_addr_q;
    assign unit_var_o      = unit_var_q;
    assign unit_value_o    = unit_value_q;
    assign sat_count_o     = sat_count_q;

endmodule

// File: tb/tb_clause_scanner.sv
// Bench for clause_scanner: hand-derived vector table, a few multi-cycle
// sequences (busy start, mid-scan reset) and randomized memories checked
// against a clause-by-clause reference model.
module tb_clause_scanner;
    import sat_pkg::*;

    localparam int NC = 16;
    localparam int AW = 4;
    localparam int CW = 5;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [CW-1:0]           num = '0;
    logic [AW-1:0]           mem_addr;
    logic [CLAUSE_WIDTH-1:0] mem_rdata = '0;
    logic                    busy, done, all_sat, conflict, unit_found, unit_value;
    logic [AW-1:0]           conflict_addr, unit_addr;
    logic [VAR_ID_WIDTH-1:0] unit_var;
    logic [CW-1:0]           sat_count;

    logic [CLAUSE_WIDTH-1:0] mem [NC];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int done_k;
        int all_sat;
        int conflict;
        int caddr;
        int ufound;
        int uaddr;
        int uvar;
        int uval;
        int sat_count;
    } exp_t;

    typedef struct {
        string      name;
        logic [1:0] va, vb, vc, vd;
        int         n;
        exp_t       e;
    } vec_t;

    clause_scanner #(.NUM_CLAUSES(NC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .num_clauses_i   (num),
        .mem_read_addr_o (mem_addr),
        .mem_read_data_i (mem_rdata),
        .busy_o          (busy),
        .done_o          (done),
        .all_sat_o       (all_sat),
        .conflict_o      (conflict),
        .conflict_addr_o (conflict_addr),
        .unit_found_o    (unit_found),
        .unit_addr_o     (unit_addr),
        .unit_var_o      (unit_var),
        .unit_value_o    (unit_value),
        .sat_count_o     (sat_count)
    );

    always #5 clk = ~clk;

    // Clause memory with a registered read port.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mkexp(input int dk, as, c, ca, uf, ua, uv, uval, sc);
        exp_t e;
        e.done_k = dk; e.all_sat = as; e.conflict = c; e.caddr = ca;
        e.ufound = uf; e.uaddr = ua; e.uvar = uv; e.uval = uval; e.sat_count = sc;
        return e;
    endfunction

    function automatic logic [TERM_WIDTH-1:0] mk_t(input int v, input logic [1:0] val, input logic ng);
        return {8'(v), val, ng};
    endfunction

    // Test clauses over A=0, B=1, C=2, D=3.
    function automatic logic [CLAUSE_WIDTH-1:0] test_clause(input int idx, input logic [1:0] a, b, c, d);
        case (idx)
            0:       return {mk_t(0, a, 1'b0), mk_t(1, b, 1'b1), mk_t(2, c, 1'b0)};
            1:       return {mk_t(0, a, 1'b1), mk_t(1, b, 1'b0), mk_t(3, d, 1'b1)};
            2:       return {mk_t(1, b, 1'b0), mk_t(2, c, 1'b0), mk_t(3, d, 1'b0)};
            default: return {mk_t(0, a, 1'b1), mk_t(2, c, 1'b1), mk_t(3, d, 1'b0)};
        endcase
    endfunction

    task automatic load_set(input logic [1:0] a, b, c, d);
        for (int i = 0; i < NC; i++) begin
            if (i < 4) mem[i] = test_clause(i, a, b, c, d);
            else       mem[i] = {mk_t(7, VAL_TRUE, 1'b0), mk_t(8, VAL_UNKNOWN, 1'b0), mk_t(9, VAL_FALSE, 1'b0)};
        end
    endtask

    // Reference: walk the clauses in order, counting literal outcomes.
    function automatic exp_t model(input int n);
        exp_t e;
        int   nn;
        nn = (n > NC) ? NC : n;
        e = mkexp((nn == 0) ? 1 : nn + 2, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < nn; c++) begin
            logic [CLAUSE_WIDTH-1:0] w;
            logic [TERM_WIDTH-1:0]   tm;
            int nt, nf, nu, uv, uval;
            w = mem[c];
            nt = 0; nf = 0; nu = 0; uv = 0; uval = 0;
            for (int j = 0; j < 3; j++) begin
                tm = w[CLAUSE_WIDTH-1-j*TERM_WIDTH -: TERM_WIDTH];
                if (tm[2:1] >= 2) begin
                    nu++; uv = int'(tm[10:3]); uval = tm[0] ? 0 : 1;
                end else if ((tm[1] ^ tm[0]) == 1'b1) nt++;
                else nf++;
            end
            if (nt > 0) e.sat_count++;
            else begin
                e.all_sat = 0;
                if (nf == 3) begin
                    e.conflict = 1; e.caddr = c; e.done_k = c + 3;
                    break;
                end else if (nu == 1) begin
                    if (e.ufound == 0) begin
                        e.uaddr = c; e.uvar = uv; e.uval = uval;
                    end
                    e.ufound = 1;
                end
            end
        end
        return e;
    endfunction

    // Start a scan, watch it to done and compare every result.
    task automatic run_scan(input string tag, input int n, input exp_t e, input bit poke);
        int dk;
        int nn;
        bit addr_ok;
        dk = -1; addr_ok = 1'b1;
        nn = (n > NC) ? NC : n;
        start = 1'b1;
        num = CW'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_on"}, busy, 1);
        if (nn > 0 && mem_addr !== 0) addr_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (poke) begin
                start = (k < 3);
                num = 1;
            end
            if (done) begin
                dk = k;
                break;
            end
            if (k <= nn - 1 && k <= e.done_k - 3 && mem_addr !== AW'(k)) addr_ok = 1'b0;
        end
        start = 1'b0;
        chk({tag, ".done_cycle"}, dk, e.done_k);
        chk({tag, ".busy_off"}, busy, 0);
        chk({tag, ".addr_seq"}, addr_ok, 1);
        chk({tag, ".all_sat"}, all_sat, e.all_sat);
        chk({tag, ".conflict"}, conflict, e.conflict);
        chk({tag, ".conflict_addr"}, conflict_addr, e.caddr);
        chk({tag, ".unit_found"}, unit_found, e.ufound);
        chk({tag, ".unit_addr"}, unit_addr, e.uaddr);
        chk({tag, ".unit_var"}, unit_var, e.uvar);
        chk({tag, ".unit_value"}, unit_value, e.uval);
        chk({tag, ".sat_count"}, sat_count, e.sat_count);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, done, 0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [1:0] U, F, T, R;
        int seen;
        U = VAL_UNKNOWN; F = VAL_FALSE; T = VAL_TRUE; R = VAL_RSVD;

        vecs[0] = '{"undecided",   U, U, U, U, 4,  mkexp(6, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1] = '{"conflict_c2", U, F, F, F, 4,  mkexp(5, 0, 1, 2, 0, 0, 0, 0, 2)};
        vecs[2] = '{"unit_c1",     T, F, U, U, 4,  mkexp(6, 0, 0, 0, 1, 1, 3, 0, 1)};
        vecs[3] = '{"all_sat",     F, F, T, T, 4,  mkexp(6, 1, 0, 0, 0, 0, 0, 0, 4)};
        vecs[4] = '{"n_zero",      U, U, U, U, 0,  mkexp(1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5] = '{"clamp20",     F, F, T, T, 20, mkexp(18, 1, 0, 0, 0, 0, 0, 0, 16)};
        vecs[6] = '{"first_unit",  T, F, F, R, 4,  mkexp(6, 0, 0, 0, 1, 1, 3, 0, 2)};
        vecs[7] = '{"conflict_c0", F, T, F, U, 4,  mkexp(3, 0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[8] = '{"unit_n1",     U, T, F, U, 1,  mkexp(3, 0, 0, 0, 1, 0, 0, 1, 0)};
        vecs[9] = '{"conflict_lst",T, U, T, F, 4,  mkexp(6, 0, 1, 3, 0, 0, 0, 0, 3)};

        for (int i = 0; i < NC; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.all_sat", all_sat, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.sat_count", sat_count, 0);
        chk("rst.unit_found", unit_found, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            load_set(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vd);
            run_scan(vecs[i].name, vecs[i].n, vecs[i].e, 1'b0);
        end

        // start pulses while busy must not restart the scan
        load_set(F, F, T, T);
        run_scan("busy_ignore", 4, mkexp(6, 1, 0, 0, 0, 0, 0, 0, 4), 1'b1);

        // Reset asserted at E0+3: everything clears, no done afterwards
        load_set(F, F, T, T);
        start = 1'b1; num = 4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midrst.pre_sat_count", sat_count, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.all_sat", all_sat, 0);
        chk("midrst.sat_count", sat_count, 0);
        chk("midrst.addr", mem_addr, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst.no_done", seen, 0);

        // Randomized memories against the reference model
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NC; i++) begin
                logic [CLAUSE_WIDTH-1:0] w;
                for (int j = 0; j < 3; j++) begin
                    int r;
                    logic [1:0] v;
                    r = $urandom_range(0, 7);
                    v = (r < 3) ? VAL_FALSE : (r < 6) ? VAL_TRUE : (r == 6) ? VAL_UNKNOWN : VAL_RSVD;
                    w[CLAUSE_WIDTH-1-j*TERM_WIDTH -: TERM_WIDTH] =
                        mk_t($urandom_range(0, 255), v, 1'($urandom_range(0, 1)));
                end
                mem[i] = w;
            end
            begin
                int n;
                n = $urandom_range(0, 20);
                run_scan($sformatf("rand%0d", it), n, model(n), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
